// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing controller.
// Walks each instruction through FETCH / DECODE / EXEC / MEM / WB, raises
// the datapath strobes for each phase, counts retired instructions and parks
// in TRAP on an unsupported opcode until the next reset.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] func_field,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [5:0] func_out,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal,
  output logic [15:0] retired
);

  // Sequencer phases.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  // Instruction class captured in DECODE; steers EXEC, MEM and WB.
  typedef enum logic [2:0] {
    C_R,
    C_LW,
    C_SW,
    C_BEQ,
    C_ADDI,
    C_ANDI,
    C_ORI,
    C_ILL
  } cls_e;

  // Opcode values recognised by the decoder.
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  // ALU class codes handed to the ALU-control decoder.
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_FUNC = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [5:0]  func_q, func_d;
  logic [15:0] retired_q, retired_d;
  cls_e        dec_cls;
  logic        done;

  // Map a raw opcode onto its instruction class.
  function automatic cls_e classify(input logic [5:0] op);
    unique case (op)
      OP_R:    classify = C_R;
      OP_LW:   classify = C_LW;
      OP_SW:   classify = C_SW;
      OP_BEQ:  classify = C_BEQ;
      OP_ADDI: classify = C_ADDI;
      OP_ANDI: classify = C_ANDI;
      OP_ORI:  classify = C_ORI;
      default: classify = C_ILL;
    endcase
  endfunction

  assign dec_cls = classify(opcode);

  // Instruction completion: the cycle after which retired advances and run
  // decides between FETCH and IDLE.
  always_comb begin
    done = 1'b0;
    unique case (state_q)
      S_EXEC:  done = (cls_q == C_BEQ);
      S_MEM:   done = (cls_q == C_SW) && mem_ready;
      S_WB:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // State, class, func and retired registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational processes.
  // NOTE: the async reset clears every flop here, which is what drops the
  // Moore strobes (e.g. mem_write mid-MEM) without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      func_q    <= 6'b000000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      func_q    <= func_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic.
  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ:      state_d = run ? S_FETCH : S_IDLE;
          C_ILL:      state_d = S_TRAP;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_LW) state_d = S_WB;
          else               state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Class/func capture in DECODE and the retired-instruction counter.
  always_comb begin
    cls_d     = cls_q;
    func_d    = func_q;
    retired_d = retired_q;
    if (state_q == S_DECODE) begin
      cls_d  = dec_cls;
      func_d = func_field;
    end
    if (done) retired_d = retired_q + 16'd1;  // wraps 0xFFFF -> 0x0000
  end

  // Moore outputs from state and latched class; FETCH completion and the
  // beq branch decision also look at mem_ready and zero in the same cycle.
  always_comb begin
    alu_op    = ALU_AND;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_op   = ALU_ADD;
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_op = ALU_ADD;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_R:                alu_op = ALU_FUNC;
          C_LW, C_SW, C_ADDI: alu_op = ALU_ADD;
          C_BEQ: begin
            alu_op   = ALU_SUB;
            pc_write = zero;
          end
          C_ANDI:             alu_op = ALU_AND;
          C_ORI:              alu_op = ALU_OR;
          default:            alu_op = ALU_AND;
        endcase
      end
      S_MEM: begin
        // Class is exactly one of LW/SW here, so the two strobes are exclusive.
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        alu_op = ALU_AND;
      end
    endcase
  end

  assign func_out = func_q;
  assign retired  = retired_q;

endmodule
